// File: rtl/tone_detector.sv
// tone_detector: measures the half-period of an asynchronous square-wave input
// in clk cycles and flags match/lock against a nominal tone.
// Optional macro GLITCH_FILTER_EN inserts a FILT_CYCLES stability filter after
// the synchronizer; without it the synced sample drives edge detection directly.
module tone_detector #(
    parameter int NOM_HALF    = 113637,
    parameter int TOL         = 1137,
    parameter int LOCK_COUNT  = 4,
    parameter int TIMEOUT     = 250000,
    parameter int CNT_W       = 18,
    parameter int FILT_CYCLES = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             audio_in,
    output logic [CNT_W-1:0] half_period,
    output logic             period_valid,
    output logic             tone_match,
    output logic             tone_lock
);

    typedef enum logic [1:0] {IDLE, ACQUIRE, MEASURE, LOCKED} state_t;

    // Window bounds are held one bit wider than the counter so cnt+1 and
    // NOM_HALF+TOL never overflow; the low bound clamps at zero.
    localparam int              MW       = CNT_W + 1;
    localparam int              RUN_W    = $clog2(LOCK_COUNT + 1);
    localparam logic [MW-1:0]   LO_BOUND = (NOM_HALF > TOL) ? MW'(NOM_HALF - TOL) : '0;
    localparam logic [MW-1:0]   HI_BOUND = MW'(NOM_HALF + TOL);
    localparam logic [MW-1:0]   MEAS_ONE = MW'(1);
    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [RUN_W-1:0] LOCK_C    = RUN_W'(LOCK_COUNT);
    localparam logic [RUN_W-1:0] RUN_ONE   = RUN_W'(1);

    logic sync1_q, sync1_d, sync2_q, sync2_d, prev_q, prev_d;
    logic det_in, edge_det;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [RUN_W-1:0] run_q, run_d, run_inc;
    logic [CNT_W-1:0] half_q, half_d;
    logic             pv_q, pv_d, match_q, match_d, lock_q, lock_d;
    logic [MW-1:0]    meas;
    logic             meas_match;

    // Two-stage synchronizer followed by the previous-sample copy for edge detection
    always_comb begin
        sync1_d = audio_in;
        sync2_d = sync1_q;
        prev_d  = det_in;
    end

    // Synchronizer and previous-sample registers
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            prev_q  <= prev_d;
        end
    end

`ifdef GLITCH_FILTER_EN
    localparam int               FILT_W    = $clog2(FILT_CYCLES + 1);
    localparam logic [FILT_W-1:0] FILT_LAST = FILT_W'(FILT_CYCLES - 1);
    localparam logic [FILT_W-1:0] FILT_ONE  = FILT_W'(1);

    logic              filt_q, filt_d;
    logic [FILT_W-1:0] filt_cnt_q, filt_cnt_d;

    // Filtered level follows the synced sample only after it has differed for FILT_CYCLES cycles
    always_comb begin
        filt_d     = filt_q;
        filt_cnt_d = '0;
        if (sync2_q != filt_q) begin
            if (filt_cnt_q == FILT_LAST) begin
                filt_d = sync2_q;
            end else begin
                filt_cnt_d = filt_cnt_q + FILT_ONE;
            end
        end
    end

    // Glitch filter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            filt_q     <= 1'b0;
            filt_cnt_q <= '0;
        end else begin
            filt_q     <= filt_d;
            filt_cnt_q <= filt_cnt_d;
        end
    end

    assign det_in = filt_q;
`else
    assign det_in = sync2_q;
`endif

    assign edge_det   = det_in ^ prev_q;
    assign meas       = {1'b0, cnt_q} + MEAS_ONE;
    assign meas_match = (meas >= LO_BOUND) && (meas <= HI_BOUND);
    assign run_inc    = (run_q == LOCK_C) ? run_q : run_q + RUN_ONE;

    // Next-state, counter and measurement logic; edges win over timeout
    always_comb begin
        state_d = state_q;
        cnt_d   = (cnt_q == TIMEOUT_C) ? cnt_q : cnt_q + CNT_ONE;
        run_d   = run_q;
        half_d  = half_q;
        pv_d    = 1'b0;
        match_d = match_q;
        lock_d  = lock_q;
        if (!enable) begin
            state_d = IDLE;
            cnt_d   = '0;
            run_d   = '0;
            match_d = 1'b0;
            lock_d  = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = ACQUIRE;
                    cnt_d   = '0;
                    run_d   = '0;
                    match_d = 1'b0;
                    lock_d  = 1'b0;
                end
                ACQUIRE: begin
                    if (edge_det) begin
                        cnt_d   = '0;
                        state_d = MEASURE;
                    end
                end
                MEASURE, LOCKED: begin
                    if (edge_det) begin
                        cnt_d   = '0;
                        half_d  = meas[CNT_W-1:0];
                        pv_d    = 1'b1;
                        match_d = meas_match;
                        if (meas_match) begin
                            run_d = run_inc;
                            if (state_q == MEASURE && run_inc == LOCK_C) begin
                                state_d = LOCKED;
                                lock_d  = 1'b1;
                            end
                        end else begin
                            run_d = '0;
                            if (state_q == LOCKED) begin
                                state_d = MEASURE;
                                lock_d  = 1'b0;
                            end
                        end
                    end else if (cnt_q == TIMEOUT_C) begin
                        state_d = ACQUIRE;
                        run_d   = '0;
                        match_d = 1'b0;
                        lock_d  = 1'b0;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // State, counter and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            run_q   <= '0;
            half_q  <= '0;
            pv_q    <= 1'b0;
            match_q <= 1'b0;
            lock_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            run_q   <= run_d;
            half_q  <= half_d;
            pv_q    <= pv_d;
            match_q <= match_d;
            lock_q  <= lock_d;
        end
    end

    assign half_period  = half_q;
    assign period_valid = pv_q;
    assign tone_match   = match_q;
    assign tone_lock    = lock_q;

endmodule

// File: tb/tb_tone_detector.sv
// Testbench for tone_detector: scaled-down parameters, a scoreboard of expected
// measurements pushed as edges are driven and popped on each period_valid.
module tb_tone_detector;

    localparam int NOM      = 100;
    localparam int TOLV     = 3;
    localparam int LOCKN    = 4;
    localparam int TMO      = 250;
    localparam int CW       = 9;
    localparam int FILT     = 16;
`ifdef GLITCH_FILTER_EN
    localparam int EDGE_LAT = 3 + FILT;
`else
    localparam int EDGE_LAT = 3;
`endif

    typedef struct {
        int half;
        int match;
        int lock;
    } exp_t;

    logic          clk;
    logic          rst;
    logic          enable;
    logic          audio_in;
    logic [CW-1:0] half_period;
    logic          period_valid;
    logic          tone_match;
    logic          tone_lock;

    exp_t sb[$];
    exp_t mon_e;
    int   total = 0;
    int   bad   = 0;
    bit   prev_pv = 0;
    bit   m_ref = 0;
    int   m_run = 0;
    bit   m_locked = 0;

    tone_detector #(
        .NOM_HALF(NOM), .TOL(TOLV), .LOCK_COUNT(LOCKN),
        .TIMEOUT(TMO), .CNT_W(CW), .FILT_CYCLES(FILT)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable), .audio_in(audio_in),
        .half_period(half_period), .period_valid(period_valid),
        .tone_match(tone_match), .tone_lock(tone_lock)
    );

    // 100 MHz clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count a comparison and report it if it disagrees
    task automatic checkOutput(input string tag, input int actual, input int expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, actual, expected);
        end
    endtask

    // Reference model of one detected edge spaced gap cycles after the previous one
    task automatic modelEdge(input int gap);
        exp_t e;
        bit m;
        if (!m_ref) begin
            m_ref = 1;
        end else begin
            m = (gap >= NOM - TOLV) && (gap <= NOM + TOLV);
            if (m) begin
                if (m_run < LOCKN) m_run++;
                if (!m_locked && m_run == LOCKN) m_locked = 1;
            end else begin
                m_run    = 0;
                m_locked = 0;
            end
            e.half  = gap;
            e.match = m ? 1 : 0;
            e.lock  = m_locked ? 1 : 0;
            sb.push_back(e);
        end
    endtask

    task automatic modelReset();
        m_ref    = 0;
        m_run    = 0;
        m_locked = 0;
    endtask

    // Toggle audio_in gap cycles after the previous toggle, optionally feeding the model
    task automatic applyStimulus(input int gap, input bit modeled);
        repeat (gap) @(posedge clk);
        #1 audio_in = ~audio_in;
        if (modeled) modelEdge(gap);
    endtask

    // Scoreboard monitor: every period_valid must match the oldest expected entry
    always @(negedge clk) begin
        if (period_valid) begin
            if (prev_pv) checkOutput("pv_back_to_back", 1, 0);
            if (sb.size() == 0) begin
                checkOutput("pv_unexpected", 1, 0);
            end else begin
                mon_e = sb.pop_front();
                checkOutput("half_period", int'(half_period), mon_e.half);
                checkOutput("tone_match", int'(tone_match), mon_e.match);
                checkOutput("tone_lock", int'(tone_lock), mon_e.lock);
            end
        end
        prev_pv = period_valid;
    end

    initial begin
        rst      = 1'b1;
        enable   = 1'b0;
        audio_in = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_half", int'(half_period), 0);
        checkOutput("rst_pv", int'(period_valid), 0);
        checkOutput("rst_match", int'(tone_match), 0);
        checkOutput("rst_lock", int'(tone_lock), 0);
        rst    = 1'b0;
        enable = 1'b1;

        // nominal tone: reference edge, then lock on the 4th pulse
        for (int i = 0; i < 6; i++) applyStimulus(NOM, 1);
        // one short half-period drops lock, then relock
        applyStimulus(80, 1);
        for (int i = 0; i < 4; i++) applyStimulus(NOM, 1);
        // tolerance boundaries
        applyStimulus(NOM + TOLV, 1);
        applyStimulus(NOM + TOLV + 1, 1);
        applyStimulus(NOM - TOLV, 1);
        applyStimulus(NOM - TOLV - 1, 1);
        for (int i = 0; i < 4; i++) applyStimulus(NOM - TOLV, 1);

        // input held constant: lock falls the cycle after cnt saturates
        repeat (EDGE_LAT + TMO) @(posedge clk);
        @(negedge clk);
        checkOutput("lock_before_timeout", int'(tone_lock), 1);
        @(posedge clk);
        @(negedge clk);
        checkOutput("lock_after_timeout", int'(tone_lock), 0);
        checkOutput("match_after_timeout", int'(tone_match), 0);
        checkOutput("half_hold_timeout", int'(half_period), NOM - TOLV);
        modelReset();
        applyStimulus(10, 1);
        applyStimulus(NOM, 1);
        applyStimulus(NOM, 1);

        // one-cycle reset mid-half-period
        repeat (50) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        checkOutput("midrst_half", int'(half_period), 0);
        checkOutput("midrst_match", int'(tone_match), 0);
        checkOutput("midrst_lock", int'(tone_lock), 0);
        modelReset();
        applyStimulus(30, 1);
        applyStimulus(NOM, 1);

        // enable dropped: outputs clear, half_period held
        repeat (50) @(posedge clk);
        #1 enable = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("dis_pv", int'(period_valid), 0);
        checkOutput("dis_match", int'(tone_match), 0);
        checkOutput("dis_lock", int'(tone_lock), 0);
        checkOutput("dis_half_hold", int'(half_period), NOM);
        enable = 1'b1;
        modelReset();
        applyStimulus(20, 1);
        applyStimulus(NOM, 1);

        // 5-cycle glitch on a low input from a fresh acquire
        repeat (50) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        modelReset();
`ifdef GLITCH_FILTER_EN
        applyStimulus(10, 0);
        applyStimulus(5, 0);
`else
        applyStimulus(10, 1);
        applyStimulus(5, 1);
`endif
        repeat (60) @(posedge clk);
        @(negedge clk);
        checkOutput("sb_empty", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
